// File: rtl/spi_reg_bank_if.sv
// Byte-level link between the SPI slave byte receiver and the register bank.
// The receiver drives chip select, byte-valid pulses, opcode latches and the
// received byte; the bank returns the next byte to shift out on MISO.
interface spi_reg_bank_if;
    logic       CSn;
    logic       slave_byte_vld;
    logic       wr_latch;
    logic       rd_latch;
    logic [7:0] slave_in;
    logic [7:0] slave_out_dat;

    // Receiver side
    modport master (
        output CSn,
        output slave_byte_vld,
        output wr_latch,
        output rd_latch,
        output slave_in,
        input  slave_out_dat
    );

    // Register bank side
    modport slave (
        input  CSn,
        input  slave_byte_vld,
        input  wr_latch,
        input  rd_latch,
        input  slave_in,
        output slave_out_dat
    );
endinterface

// File: rtl/spi_reg_bank.sv
// Register bank behind the SPI slave byte receiver. The first flagged byte of
// a transaction is the address; later bytes are written to or read from a
// 2^ADDR_W x 8 byte array with auto-increment. Address 0 is a read-only ID.
module spi_reg_bank #(
    parameter int unsigned ADDR_W = 4,
    parameter logic [7:0]  ID_VAL = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_reg_bank_if.slave     bus,
    input  logic [ADDR_W-1:0] loc_rd_addr,
    output logic [7:0]        loc_rd_dat,
    output logic              wr_evt,
    output logic [ADDR_W-1:0] wr_evt_addr,
    output logic [7:0]        wr_evt_dat
);

    localparam int unsigned Depth = 1 << ADDR_W;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StWdata,
        StRdata
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        mem_q [Depth];
    logic [7:0]        mem_d [Depth];
    logic [7:0]        out_q, out_d;
    logic              evt_q, evt_d;
    logic [ADDR_W-1:0] evt_addr_q, evt_addr_d;
    logic [7:0]        evt_dat_q, evt_dat_d;

    logic [ADDR_W-1:0] byte_addr;
    logic [ADDR_W-1:0] rd_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        rd_val;

    // Read-source select: the address byte itself in StAddr, else the pointer.
    // ptr_q points one past the byte being written, hence wr_addr = ptr_q - 1.
    always_comb begin
        byte_addr = bus.slave_in[ADDR_W-1:0];
        rd_sel    = (state_q == StAddr) ? byte_addr : ptr_q;
        rd_val    = (rd_sel == '0) ? ID_VAL : mem_q[rd_sel];
        wr_addr   = ptr_q - ADDR_W'(1);
    end

    // Next-state, pointer, memory and output-byte update.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        mem_d      = mem_q;
        out_d      = out_q;
        evt_d      = 1'b0;
        evt_addr_d = evt_addr_q;
        evt_dat_d  = evt_dat_q;

        if (bus.CSn) begin
            // Deselect aborts: no write or pointer move in this clock.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StAddr;
                end
                StAddr: begin
                    // Write wins if both opcode latches are set; neither = ignore.
                    if (bus.slave_byte_vld && bus.wr_latch) begin
                        state_d = StWdata;
                        ptr_d   = byte_addr + ADDR_W'(1);
                    end else if (bus.slave_byte_vld && bus.rd_latch) begin
                        state_d = StRdata;
                        ptr_d   = byte_addr + ADDR_W'(1);
                        out_d   = rd_val;
                    end
                end
                StWdata: begin
                    if (bus.slave_byte_vld) begin
                        if (wr_addr != '0) begin
                            mem_d[wr_addr] = bus.slave_in;
                            evt_d          = 1'b1;
                            evt_addr_d     = wr_addr;
                            evt_dat_d      = bus.slave_in;
                        end
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
                StRdata: begin
                    if (bus.slave_byte_vld) begin
                        out_d = rd_val;
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            out_q      <= '0;
            evt_q      <= 1'b0;
            evt_addr_q <= '0;
            evt_dat_q  <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            out_q      <= out_d;
            evt_q      <= evt_d;
            evt_addr_q <= evt_addr_d;
            evt_dat_q  <= evt_dat_d;
            mem_q      <= mem_d;
        end
    end

    // Local read port sees the registered array, so a same-clock write shows old data.
    always_comb begin
        loc_rd_dat = (loc_rd_addr == '0) ? ID_VAL : mem_q[loc_rd_addr];
    end

    assign bus.slave_out_dat = out_q;
    assign wr_evt            = evt_q;
    assign wr_evt_addr       = evt_addr_q;
    assign wr_evt_dat        = evt_dat_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: a per-clock vector table for the main
// transactions plus hand-written sequences for timing, abort and reset cases.
module tb_spi_reg_bank;

    localparam int unsigned AW = 4;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] loc_rd_addr;
    logic [7:0]    loc_rd_dat;
    logic          wr_evt;
    logic [AW-1:0] wr_evt_addr;
    logic [7:0]    wr_evt_dat;

    spi_reg_bank_if bus ();

    spi_reg_bank #(
        .ADDR_W (AW),
        .ID_VAL (8'hA5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .loc_rd_addr (loc_rd_addr),
        .loc_rd_dat  (loc_rd_dat),
        .wr_evt      (wr_evt),
        .wr_evt_addr (wr_evt_addr),
        .wr_evt_dat  (wr_evt_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cs;
        logic       vld;
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [3:0] la;
        logic [7:0] eo;
        logic       ee;
        logic [3:0] ea;
        logic [7:0] ed;
        logic [7:0] el;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic cs, input logic vld, input logic wr, input logic rd,
                         input logic [7:0] din, input logic [3:0] la);
        bus.CSn            = cs;
        bus.slave_byte_vld = vld;
        bus.wr_latch       = wr;
        bus.rd_latch       = rd;
        bus.slave_in       = din;
        loc_rd_addr        = la;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic cs, input logic vld, input logic wr, input logic rd,
                       input logic [7:0] din, input logic [3:0] la, input logic [7:0] eo,
                       input logic ee, input logic [3:0] ea, input logic [7:0] ed,
                       input logic [7:0] el);
        vec_t v;
        v.cs = cs; v.vld = vld; v.wr = wr; v.rd = rd; v.din = din; v.la = la;
        v.eo = eo; v.ee = ee; v.ea = ea; v.ed = ed; v.el = el;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        //  cs vld wr rd din    la     eo     ee ea     ed     el
        // Read address 0: address byte loads ID, dummy byte loads mem[1]
        add(1, 0, 0, 0, 8'h00, 4'h0, 8'h00, 0, 4'h0, 8'h00, 8'hA5);
        add(0, 0, 0, 1, 8'h00, 4'h0, 8'h00, 0, 4'h0, 8'h00, 8'hA5);
        add(0, 1, 0, 1, 8'h00, 4'h0, 8'hA5, 0, 4'h0, 8'h00, 8'hA5);
        add(0, 0, 0, 1, 8'h00, 4'h0, 8'hA5, 0, 4'h0, 8'h00, 8'hA5);
        add(0, 1, 0, 1, 8'hFF, 4'h0, 8'h00, 0, 4'h0, 8'h00, 8'hA5);
        add(1, 0, 0, 0, 8'h00, 4'h0, 8'h00, 0, 4'h0, 8'h00, 8'hA5);
        // Write 0x11,0x22 from address 3
        add(0, 0, 1, 0, 8'h00, 4'h3, 8'h00, 0, 4'h0, 8'h00, 8'h00);
        add(0, 1, 1, 0, 8'h03, 4'h3, 8'h00, 0, 4'h0, 8'h00, 8'h00);
        add(0, 1, 1, 0, 8'h11, 4'h3, 8'h00, 1, 4'h3, 8'h11, 8'h11);
        add(0, 0, 1, 0, 8'h00, 4'h3, 8'h00, 0, 4'h0, 8'h00, 8'h11);
        add(0, 1, 1, 0, 8'h22, 4'h4, 8'h00, 1, 4'h4, 8'h22, 8'h22);
        add(1, 0, 0, 0, 8'h00, 4'h4, 8'h00, 0, 4'h0, 8'h00, 8'h22);
        // Write from 15: wraps, write to 0 dropped, next lands in 1
        add(0, 0, 1, 0, 8'h00, 4'hF, 8'h00, 0, 4'h0, 8'h00, 8'h00);
        add(0, 1, 1, 0, 8'h0F, 4'hF, 8'h00, 0, 4'h0, 8'h00, 8'h00);
        add(0, 1, 1, 0, 8'h77, 4'hF, 8'h00, 1, 4'hF, 8'h77, 8'h77);
        add(0, 1, 1, 0, 8'h88, 4'h0, 8'h00, 0, 4'h0, 8'h00, 8'hA5);
        add(0, 1, 1, 0, 8'h44, 4'h1, 8'h00, 1, 4'h1, 8'h44, 8'h44);
        add(1, 0, 0, 0, 8'h00, 4'h1, 8'h00, 0, 4'h0, 8'h00, 8'h44);
        // Read from 15 with wrap: 0x77, ID, 0x44; holds in idle
        add(0, 0, 0, 1, 8'h00, 4'hF, 8'h00, 0, 4'h0, 8'h00, 8'h77);
        add(0, 1, 0, 1, 8'h0F, 4'hF, 8'h77, 0, 4'h0, 8'h00, 8'h77);
        add(0, 1, 0, 1, 8'h00, 4'hF, 8'hA5, 0, 4'h0, 8'h00, 8'h77);
        add(0, 1, 0, 1, 8'h00, 4'h1, 8'h44, 0, 4'h0, 8'h00, 8'h44);
        add(1, 0, 0, 0, 8'h00, 4'h1, 8'h44, 0, 4'h0, 8'h00, 8'h44);
        add(1, 0, 0, 0, 8'h00, 4'h4, 8'h44, 0, 4'h0, 8'h00, 8'h22);
        // Unknown opcode: bytes ignored
        add(0, 0, 0, 0, 8'h00, 4'h2, 8'h44, 0, 4'h0, 8'h00, 8'h00);
        add(0, 1, 0, 0, 8'h02, 4'h2, 8'h44, 0, 4'h0, 8'h00, 8'h00);
        add(0, 1, 0, 0, 8'h99, 4'h2, 8'h44, 0, 4'h0, 8'h00, 8'h00);
        add(1, 0, 0, 0, 8'h00, 4'h2, 8'h44, 0, 4'h0, 8'h00, 8'h00);
        // Both latches set: write wins, MISO byte untouched
        add(0, 0, 1, 1, 8'h00, 4'h6, 8'h44, 0, 4'h0, 8'h00, 8'h00);
        add(0, 1, 1, 1, 8'h06, 4'h6, 8'h44, 0, 4'h0, 8'h00, 8'h00);
        add(0, 1, 1, 1, 8'h5A, 4'h6, 8'h44, 1, 4'h6, 8'h5A, 8'h5A);
        add(1, 0, 0, 0, 8'h00, 4'h6, 8'h44, 0, 4'h0, 8'h00, 8'h5A);

        // Reset
        rst_n = 1'b0;
        drive(1, 0, 0, 0, 8'h00, 4'h3);
        tick;
        tick;
        chk("rst_out", bus.slave_out_dat, 8'h00);
        chk("rst_evt", wr_evt, 1'b0);
        chk("rst_evt_addr", wr_evt_addr, 4'h0);
        chk("rst_evt_dat", wr_evt_dat, 8'h00);
        chk("rst_loc3", loc_rd_dat, 8'h00);
        drive(1, 0, 0, 0, 8'h00, 4'h0);
        chk("rst_loc0", loc_rd_dat, 8'hA5);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].cs, vecs[i].vld, vecs[i].wr, vecs[i].rd, vecs[i].din, vecs[i].la);
            tick;
            chk($sformatf("row%0d_out", i), bus.slave_out_dat, vecs[i].eo);
            chk($sformatf("row%0d_evt", i), wr_evt, vecs[i].ee);
            if (vecs[i].ee) begin
                chk($sformatf("row%0d_evt_addr", i), wr_evt_addr, vecs[i].ea);
                chk($sformatf("row%0d_evt_dat", i), wr_evt_dat, vecs[i].ed);
            end
            chk($sformatf("row%0d_loc", i), loc_rd_dat, vecs[i].el);
        end

        // Read from 3: MISO byte changes only at the edge that samples vld
        drive(0, 0, 0, 1, 8'h00, 4'h0);
        tick;
        drive(0, 1, 0, 1, 8'h03, 4'h0);
        chk("rd_pre_addr", bus.slave_out_dat, 8'h44);
        tick;
        chk("rd_post_addr", bus.slave_out_dat, 8'h11);
        drive(0, 0, 0, 1, 8'h00, 4'h0);
        tick;
        chk("rd_hold1", bus.slave_out_dat, 8'h11);
        tick;
        chk("rd_hold2", bus.slave_out_dat, 8'h11);
        drive(0, 1, 0, 1, 8'hFF, 4'h0);
        chk("rd_pre_dat", bus.slave_out_dat, 8'h11);
        tick;
        chk("rd_post_dat", bus.slave_out_dat, 8'h22);
        drive(0, 0, 0, 1, 8'h00, 4'h0);
        tick;
        chk("rd_hold3", bus.slave_out_dat, 8'h22);
        drive(1, 0, 0, 0, 8'h00, 4'h0);
        tick;

        // Write aborted after the address byte, then a fresh write to 5
        drive(0, 0, 1, 0, 8'h00, 4'h7);
        tick;
        drive(0, 1, 1, 0, 8'h07, 4'h7);
        tick;
        drive(1, 1, 1, 0, 8'hEE, 4'h7);
        tick;
        chk("abort_evt", wr_evt, 1'b0);
        chk("abort_loc7", loc_rd_dat, 8'h00);
        drive(1, 0, 0, 0, 8'h00, 4'h7);
        tick;
        drive(0, 0, 1, 0, 8'h00, 4'h5);
        tick;
        drive(0, 1, 1, 0, 8'h05, 4'h5);
        tick;
        chk("w5_addr_evt", wr_evt, 1'b0);
        drive(0, 1, 1, 0, 8'h33, 4'h5);
        chk("w5_loc_old", loc_rd_dat, 8'h00);
        tick;
        chk("w5_evt", wr_evt, 1'b1);
        chk("w5_evt_addr", wr_evt_addr, 4'h5);
        chk("w5_evt_dat", wr_evt_dat, 8'h33);
        chk("w5_loc_new", loc_rd_dat, 8'h33);
        drive(1, 0, 0, 0, 8'h00, 4'h7);
        tick;
        chk("w5_evt_clear", wr_evt, 1'b0);
        chk("w5_loc7", loc_rd_dat, 8'h00);
        drive(1, 0, 0, 0, 8'h00, 4'h8);
        chk("w5_loc8", loc_rd_dat, 8'h00);

        // Reset mid-write: back to idle, so the next byte is not written
        drive(0, 0, 1, 0, 8'h00, 4'hA);
        tick;
        drive(0, 1, 1, 0, 8'h0A, 4'hA);
        tick;
        rst_n = 1'b0;
        drive(0, 0, 1, 0, 8'h00, 4'h5);
        tick;
        chk("mid_rst_loc5", loc_rd_dat, 8'h00);
        chk("mid_rst_out", bus.slave_out_dat, 8'h00);
        rst_n = 1'b1;
        drive(0, 1, 1, 0, 8'hBB, 4'hA);
        tick;
        chk("mid_rst_evt", wr_evt, 1'b0);
        chk("mid_rst_locA", loc_rd_dat, 8'h00);
        drive(1, 0, 0, 0, 8'h00, 4'h0);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
